nn_phase_seq: RTL and testbench

Parametrised phase sequencer for the neural-net datapath. It drives the forward-hidden, forward-output, backward-hidden and backward-output enables (fph/fpo/bph/bpo) through a training or validation schedule. It is the generalised successor of the fixed 6-bit sequencer, with these additions:
- programmable phase lengths
- multi-sample batches with a sample index
- a start/busy/done handshake
- asynchronous reset

---
 rtl/nn_seq_pkg.sv | 46 ++++
 rtl/nn_phase_timer.sv | 23 ++
 rtl/nn_phase_seq.sv | 127 ++++++++++++
 tb/tb_nn_phase_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/nn_seq_pkg.sv
// Shared types for the neural-net phase sequencer: state encoding, per-state
// enable vectors {fph,fpo,bph,bpo} and default phase lengths.
package nn_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FH   = 3'd1,
    FO   = 3'd2,
    HO   = 3'd3,
    BO   = 3'd4,
    HB   = 3'd5,
    BOH  = 3'd6,
    TAIL = 3'd7
  } state_t;

  // enable vectors, bit order {fph,fpo,bph,bpo}
  localparam logic [3:0] EN_IDLE = 4'b0000;
  localparam logic [3:0] EN_FH   = 4'b1000;
  localparam logic [3:0] EN_FO   = 4'b0100;
  localparam logic [3:0] EN_HO   = 4'b0101;
  localparam logic [3:0] EN_BO   = 4'b0001;
  localparam logic [3:0] EN_HB   = 4'b1011;
  localparam logic [3:0] EN_BOH  = 4'b0011;
  localparam logic [3:0] EN_TAIL = 4'b0001;

  localparam int DEF_FH_CYC      = 4;
  localparam int DEF_FO_CYC      = 17;
  localparam int DEF_BO_CYC      = 15;
  localparam int DEF_BOH_CYC     = 9;
  localparam int DEF_TAIL_CYC    = 8;
  localparam int DEF_NUM_SAMPLES = 1;

  function automatic logic [3:0] state_en(input state_t s);
    case (s)
      FH:      return EN_FH;
      FO:      return EN_FO;
      HO:      return EN_HO;
      BO:      return EN_BO;
      HB:      return EN_HB;
      BOH:     return EN_BOH;
      TAIL:    return EN_TAIL;
      default: return EN_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/nn_phase_timer.sv
// Loadable down-counter; tc is high while the count is zero, so a load of
// N-1 on state entry gives a state lasting exactly N cycles.
module nn_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - CNT_W'(1);
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/nn_phase_seq.sv
// Phase sequencer driving fph/fpo/bph/bpo through training or validation
// batches. Optional abort input enabled by defining NN_SEQ_ABORT_EN.
module nn_phase_seq
  import nn_seq_pkg::*;
#(
  parameter int FH_CYC      = DEF_FH_CYC,
  parameter int FO_CYC      = DEF_FO_CYC,
  parameter int BO_CYC      = DEF_BO_CYC,
  parameter int BOH_CYC     = DEF_BOH_CYC,
  parameter int TAIL_CYC    = DEF_TAIL_CYC,
  parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
  parameter int CNT_W       = 8,
  parameter int IDX_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_tr,
  input  logic             start_vl,
`ifdef NN_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             fph,
  output logic             fpo,
  output logic             bph,
  output logic             bpo,
  output logic             busy,
  output logic             done,
  output logic             mode_tr,
  output logic [IDX_W-1:0] sample_idx
);

  if (FH_CYC < 1 || FO_CYC < 1 || BO_CYC < 1 || BOH_CYC < 1 || TAIL_CYC < 1) begin : g_bad_cyc
    $error("nn_phase_seq: every *_CYC parameter must be at least 1");
  end
  if (FH_CYC >= 2**CNT_W || FO_CYC >= 2**CNT_W || BO_CYC >= 2**CNT_W ||
      BOH_CYC >= 2**CNT_W || TAIL_CYC >= 2**CNT_W) begin : g_bad_cnt_w
    $error("nn_phase_seq: CNT_W too narrow for phase lengths");
  end
  if (NUM_SAMPLES < 1 || NUM_SAMPLES > 2**IDX_W) begin : g_bad_samples
    $error("nn_phase_seq: NUM_SAMPLES out of range for IDX_W");
  end

  localparam logic [CNT_W-1:0] LD_FH   = CNT_W'(FH_CYC - 1);
  localparam logic [CNT_W-1:0] LD_FO   = CNT_W'(FO_CYC - 1);
  localparam logic [CNT_W-1:0] LD_BO   = CNT_W'(BO_CYC - 1);
  localparam logic [CNT_W-1:0] LD_BOH  = CNT_W'(BOH_CYC - 1);
  localparam logic [CNT_W-1:0] LD_TAIL = CNT_W'(TAIL_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);

  state_t           state, nxt;
  logic             ld, tc, eos, last;
  logic [CNT_W-1:0] ldv;
  logic             nxt_mode, nxt_done;
  logic [IDX_W-1:0] nxt_idx;

  nn_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ld),
    .load_val (ldv),
    .tc       (tc)
  );

  assign last = (sample_idx >= LAST_IDX);

  // Single-cycle states (HO, HB) load 0 so tc is already set on entry.
  always_comb begin
    nxt      = state;
    ld       = 1'b0;
    ldv      = '0;
    nxt_mode = mode_tr;
    nxt_idx  = sample_idx;
    nxt_done = 1'b0;
    eos      = 1'b0;
    case (state)
      IDLE: if (start_tr || start_vl) begin
        nxt = FH; ld = 1'b1; ldv = LD_FH; nxt_mode = start_tr; nxt_idx = '0;
      end
      FH:   if (tc) begin nxt = FO; ld = 1'b1; ldv = LD_FO; end
      FO:   if (tc) begin
        if (mode_tr) begin nxt = HO; ld = 1'b1; ldv = '0; end
        else eos = 1'b1;
      end
      HO:   if (tc) begin nxt = BO; ld = 1'b1; ldv = LD_BO; end
      BO:   if (tc) begin nxt = HB; ld = 1'b1; ldv = '0; end
      HB:   if (tc) begin nxt = BOH; ld = 1'b1; ldv = LD_BOH; end
      BOH:  if (tc) begin nxt = TAIL; ld = 1'b1; ldv = LD_TAIL; end
      TAIL: if (tc) eos = 1'b1;
      default: begin nxt = IDLE; ld = 1'b1; end
    endcase
    // next sample follows with no gap; only the final sample raises done
    if (eos) begin
      ld = 1'b1;
      if (!last) begin
        nxt = FH; ldv = LD_FH; nxt_idx = sample_idx + IDX_W'(1);
      end else begin
        nxt = IDLE; ldv = '0; nxt_done = 1'b1;
      end
    end
`ifdef NN_SEQ_ABORT_EN
    if (abort && state != IDLE) begin
      nxt = IDLE; ld = 1'b1; ldv = '0; nxt_done = 1'b0;
      nxt_idx = sample_idx; nxt_mode = mode_tr;
    end
`endif
  end

  // outputs are registered from the next state so they align with state
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      {fph, fpo, bph, bpo} <= EN_IDLE;
      busy               <= 1'b0;
      done               <= 1'b0;
      mode_tr            <= 1'b0;
      sample_idx         <= '0;
    end else begin
      state              <= nxt;
      {fph, fpo, bph, bpo} <= state_en(nxt);
      busy               <= (nxt != IDLE);
      done               <= nxt_done;
      mode_tr            <= nxt_mode;
      sample_idx         <= nxt_idx;
    end
  end

endmodule

// File: tb/tb_nn_phase_seq.sv
// Bench for nn_phase_seq: table-driven batches, randomized batches with
// spurious starts, async reset mid-run and optional abort.
module tb_nn_phase_seq;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic rst_n, start_tr, start_vl, start_tr3, start_vl3;
  logic fph, fpo, bph, bpo, busy, done, mode_tr;
  logic fph3, fpo3, bph3, bpo3, busy3, done3, mode_tr3;
  logic [7:0] sample_idx, sample_idx3;
`ifdef NN_SEQ_ABORT_EN
  logic abort;
`endif

  int errors = 0;
  int checks = 0;

  nn_phase_seq dut (
    .clk(clk), .rst_n(rst_n), .start_tr(start_tr), .start_vl(start_vl),
`ifdef NN_SEQ_ABORT_EN
    .abort(abort),
`endif
    .fph(fph), .fpo(fpo), .bph(bph), .bpo(bpo), .busy(busy), .done(done),
    .mode_tr(mode_tr), .sample_idx(sample_idx)
  );

  nn_phase_seq #(.NUM_SAMPLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start_tr(start_tr3), .start_vl(start_vl3),
`ifdef NN_SEQ_ABORT_EN
    .abort(abort),
`endif
    .fph(fph3), .fpo(fpo3), .bph(bph3), .bpo(bpo3), .busy(busy3), .done(done3),
    .mode_tr(mode_tr3), .sample_idx(sample_idx3)
  );

  // Expected {fph,fpo,bph,bpo,busy,done} k cycles after the accept edge,
  // from the documented default intervals.
  function automatic logic [5:0] model(input int k, input bit tr, input int n);
    int L;
    int c;
    logic [5:0] r;
    L = tr ? 55 : 21;
    r = '0;
    if (k < n * L) begin
      c = k % L;
      r[5] = (c <= 3) || (tr && c == 37);
      r[4] = (c >= 4 && c <= 20) || (tr && c == 21);
      r[3] = tr && c >= 37 && c <= 46;
      r[2] = tr && c >= 21 && c <= 54;
      r[1] = 1'b1;
    end else if (k == n * L) begin
      r[0] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [5:0] get_out(input bit use3);
    return use3 ? {fph3, fpo3, bph3, bpo3, busy3, done3}
                : {fph, fpo, bph, bpo, busy, done};
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, k, got, exp);
    end
  endtask

  // Starts a batch now (DUT must be idle) and checks every cycle up to the
  // done cycle, or only up to stop_at if stop_at >= 0.
  task automatic run_batch(input bit tr, input bit vl, input int spur, input bit use3,
                           input bit exp_mode, input int total, input int stop_at);
    int n;
    int L;
    n = use3 ? 3 : 1;
    L = exp_mode ? 55 : 21;
    if (use3) begin start_tr3 = tr; start_vl3 = vl; end
    else begin start_tr = tr; start_vl = vl; end
    for (int k = 0; k <= total; k++) begin
      @(posedge clk);
      start_tr = 0; start_vl = 0; start_tr3 = 0; start_vl3 = 0;
      if (k == spur) begin
        if (use3) begin start_tr3 = 1; start_vl3 = 1; end
        else begin start_tr = 1; start_vl = 1; end
      end
      chk("enables", k, 32'(get_out(use3)), 32'(model(k, exp_mode, n)));
      chk("mode_tr", k, 32'(use3 ? mode_tr3 : mode_tr), 32'(exp_mode));
      chk("sample_idx", k, 32'(use3 ? sample_idx3 : sample_idx),
          (k < total) ? 32'(k / L) : 32'(n - 1));
      if (k == stop_at) begin
        start_tr = 0; start_vl = 0; start_tr3 = 0; start_vl3 = 0;
        return;
      end
    end
  endtask

  typedef struct {
    bit tr;
    bit vl;
    int spur;
    bit use3;
    bit exp_mode;
    int exp_total;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{tr: 1, vl: 0, spur: -1, use3: 0, exp_mode: 1, exp_total: 55};
    vecs[1] = '{tr: 0, vl: 1, spur: -1, use3: 0, exp_mode: 0, exp_total: 21};
    vecs[2] = '{tr: 1, vl: 1, spur: 10, use3: 0, exp_mode: 1, exp_total: 55};
    vecs[3] = '{tr: 0, vl: 1, spur: 5,  use3: 0, exp_mode: 0, exp_total: 21};
    vecs[4] = '{tr: 1, vl: 0, spur: -1, use3: 1, exp_mode: 1, exp_total: 165};

    rst_n = 0; start_tr = 0; start_vl = 0; start_tr3 = 0; start_vl3 = 0;
`ifdef NN_SEQ_ABORT_EN
    abort = 0;
`endif
    repeat (2) @(posedge clk);
    chk("reset_out", 0, 32'(get_out(0)), 32'd0);
    chk("reset_out3", 0, 32'(get_out(1)), 32'd0);
    chk("reset_idx", 0, 32'(sample_idx), 32'd0);
    chk("reset_mode", 0, 32'(mode_tr), 32'd0);
    rst_n = 1;
    @(posedge clk);

    // table rows back to back: each start lands on the edge ending done
    foreach (vecs[i])
      run_batch(vecs[i].tr, vecs[i].vl, vecs[i].spur, vecs[i].use3,
                vecs[i].exp_mode, vecs[i].exp_total, -1);

    // randomized batches with idle gaps and ignored mid-run starts
    for (int it = 0; it < 8; it++) begin
      bit tr, vl;
      int L, spur, gap;
      tr = 1'($urandom_range(0, 1));
      vl = tr ? 1'($urandom_range(0, 1)) : 1'b1;
      L = tr ? 55 : 21;
      spur = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, L - 2)) : -1;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        chk("idle_gap", g, 32'(get_out(0)), 32'd0);
      end
      run_batch(tr, vl, spur, 0, tr, L, -1);
    end

    // async reset at cycle 30 of a training run
    @(posedge clk);
    run_batch(1, 0, -1, 0, 1, 55, 30);
    #2 rst_n = 0;
    #1 chk("async_reset_out", 30, 32'(get_out(0)), 32'd0);
    chk("async_reset_idx", 30, 32'(sample_idx), 32'd0);
    chk("async_reset_mode", 30, 32'(mode_tr), 32'd0);
    repeat (2) begin
      @(posedge clk);
      chk("held_reset", 31, 32'(get_out(0)), 32'd0);
    end
    rst_n = 1;
    @(posedge clk);
    chk("post_reset_idle", 0, 32'(get_out(0)), 32'd0);
    run_batch(1, 0, -1, 0, 1, 55, -1);

`ifdef NN_SEQ_ABORT_EN
    @(posedge clk);
    run_batch(1, 0, -1, 0, 1, 55, 25);
    abort = 1;
    @(posedge clk);
    abort = 0;
    chk("abort_out", 26, 32'(get_out(0)), 32'd0);
    @(posedge clk);
    chk("abort_no_done", 27, 32'(get_out(0)), 32'd0);
    run_batch(1, 0, -1, 0, 1, 55, -1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
